// File: rtl/echo_path_if.sv
// Sample/result bundle for the echo path model.
// master drives far/near samples and settings; slave returns echo/mic results.
interface echo_path_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] far_in;
    logic [DATA_W-1:0] near_in;
    logic [ADDR_W-1:0] delay_sel;
    logic [15:0]       gain;
    logic              out_valid;
    logic [DATA_W-1:0] echo_out;
    logic [DATA_W-1:0] mic_out;
    logic [15:0]       sat_cnt;

    modport master (
        output in_valid, far_in, near_in, delay_sel, gain,
        input  in_ready, out_valid, echo_out, mic_out, sat_cnt
    );

    modport slave (
        input  in_valid, far_in, near_in, delay_sel, gain,
        output in_ready, out_valid, echo_out, mic_out, sat_cnt
    );
endinterface

// File: rtl/echo_path_model.sv
// Acoustic echo path: circular delay line, Q1.15 gain, saturating mic sum.
// Ports: clk, rst_n (async, active low), bus (echo_path_if.slave).
module echo_path_model #(
    parameter int DATA_W    = 16,
    parameter int MAX_DELAY = 64,
    parameter int ADDR_W    = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    echo_path_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        MAC  = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam int PW = DATA_W + 16;

    localparam logic signed [PW-1:0] E_MAX =
        {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PW-1:0] E_MIN =
        {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    localparam logic [DATA_W-1:0] D_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] D_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    localparam logic [ADDR_W-1:0] FILL_TOP = ADDR_W'(MAX_DELAY - 1);

    state_t state;
    state_t state_nx;

    logic [DATA_W-1:0] mem [MAX_DELAY];

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] fill_cnt;
    logic [ADDR_W-1:0] rd_addr;

    logic [DATA_W-1:0] far_q;
    logic [DATA_W-1:0] near_q;
    logic [15:0]       gain_q;
    logic              bypass;
    logic              zero_op;

    logic signed [DATA_W-1:0] operand;
    logic signed [DATA_W-1:0] echo_q;

    logic signed [PW-1:0] product;
    logic signed [PW-1:0] shifted;
    logic [DATA_W-1:0]    echo_sat;

    logic [DATA_W:0]   sum;
    logic              mic_ovf;
    logic [DATA_W-1:0] mic_sat;

    logic              accept;
    logic              out_valid_q;
    logic [DATA_W-1:0] echo_out_q;
    logic [DATA_W-1:0] mic_out_q;
    logic [15:0]       sat_cnt_q;

    assign accept       = bus.in_valid && (state == IDLE);
    assign bus.in_ready = (state == IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: fixed four-step walk, leaving IDLE only on acceptance
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.in_valid) state_nx = READ;
            READ:    state_nx = MAC;
            MAC:     state_nx = OUT;
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Delay-line storage; left uninitialised, fill_cnt hides stale words
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= bus.far_in;
        end
    end

    // Acceptance: latch inputs and advance pointer and fill level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            fill_cnt <= '0;
            rd_addr  <= '0;
            far_q    <= '0;
            near_q   <= '0;
            gain_q   <= '0;
            bypass   <= 1'b0;
            zero_op  <= 1'b0;
        end else if (accept) begin
            far_q   <= bus.far_in;
            near_q  <= bus.near_in;
            gain_q  <= bus.gain;
            rd_addr <= wr_ptr - bus.delay_sel;
            bypass  <= (bus.delay_sel == '0);
            // Compare against fill level before this sample counts
            zero_op <= (bus.delay_sel > fill_cnt);
            wr_ptr  <= wr_ptr + 1'b1;
            if (fill_cnt != FILL_TOP) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

    // Echo arithmetic: floor shift back to Q0, then clamp
    assign product = $signed(operand) * $signed(gain_q);
    assign shifted = product >>> 15;

    always_comb begin
        echo_sat = shifted[DATA_W-1:0];
        if (shifted > E_MAX) begin
            echo_sat = D_MAX;
        end else if (shifted < E_MIN) begin
            echo_sat = D_MIN;
        end
    end

    // Mic sum one bit wider so overflow shows up as a sign disagreement
    assign sum = {near_q[DATA_W-1], near_q}
               + {echo_q[DATA_W-1], echo_q};
    assign mic_ovf = sum[DATA_W] ^ sum[DATA_W-1];

    always_comb begin
        mic_sat = sum[DATA_W-1:0];
        if (mic_ovf) begin
            mic_sat = sum[DATA_W] ? D_MIN : D_MAX;
        end
    end

    // Datapath pipeline through READ, MAC and OUT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand     <= '0;
            echo_q      <= '0;
            out_valid_q <= 1'b0;
            echo_out_q  <= '0;
            mic_out_q   <= '0;
            sat_cnt_q   <= '0;
        end else begin
            out_valid_q <= 1'b0;
            unique case (state)
                READ: begin
                    if (bypass) begin
                        operand <= far_q;
                    end else if (zero_op) begin
                        operand <= '0;
                    end else begin
                        operand <= mem[rd_addr];
                    end
                end
                MAC: begin
                    echo_q <= echo_sat;
                end
                OUT: begin
                    echo_out_q  <= echo_q;
                    mic_out_q   <= mic_sat;
                    out_valid_q <= 1'b1;
                    if (mic_ovf && sat_cnt_q != 16'hFFFF) begin
                        sat_cnt_q <= sat_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.echo_out  = echo_out_q;
    assign bus.mic_out   = mic_out_q;
    assign bus.sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_echo_path_model.sv
// Scoreboard bench for echo_path_model.
// Stimulus pushes expected results; a negedge monitor pops and compares.
module tb_echo_path_model;

    logic clk;
    logic rst_n;

    echo_path_if #(.DATA_W(16), .ADDR_W(6)) bus_if ();

    echo_path_model #(
        .DATA_W(16),
        .MAX_DELAY(64),
        .ADDR_W(6)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus_if)
    );

    typedef struct {
        logic [15:0] echo;
        logic [15:0] mic;
        logic [15:0] sat;
    } exp_t;

    exp_t        sb[$];
    int          checks;
    int          passes;
    logic [15:0] sat_exp;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)",
                     name, $signed(act), act, $signed(exp), exp);
        end
    endtask

    task automatic fail_now(string name);
        checks++;
        $display("FAIL %s", name);
    endtask

    // Monitor: every out_valid pulse must match the oldest expectation
    always @(negedge clk) begin
        if (bus_if.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                fail_now("spurious_out_valid");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("echo_out", bus_if.echo_out, e.echo);
                check("mic_out", bus_if.mic_out, e.mic);
                check("sat_cnt", bus_if.sat_cnt, e.sat);
            end
        end
    end

    task automatic do_reset();
        bus_if.in_valid  = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        sat_exp = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic send(int far, int near, int d, int g,
                        int e_exp, int m_exp, bit sat);
        int n;
        n = 0;
        @(negedge clk);
        while (bus_if.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus_if.in_ready !== 1'b1) begin
            fail_now("in_ready_timeout");
            return;
        end
        bus_if.far_in    = 16'(far);
        bus_if.near_in   = 16'(near);
        bus_if.delay_sel = 6'(d);
        bus_if.gain      = 16'(g);
        bus_if.in_valid  = 1'b1;
        @(posedge clk);
        if (sat && sat_exp != 16'hFFFF) sat_exp = sat_exp + 1'b1;
        sb.push_back('{16'(e_exp), 16'(m_exp), sat_exp});
        #1 bus_if.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) fail_now("drain_timeout");
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int rdy;
        int e;
        checks = 0;
        passes = 0;
        bus_if.in_valid  = 1'b0;
        bus_if.far_in    = '0;
        bus_if.near_in   = '0;
        bus_if.delay_sel = '0;
        bus_if.gain      = '0;

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_in_ready", 16'(bus_if.in_ready), 16'd1);
        check("rst_out_valid", 16'(bus_if.out_valid), 16'd0);
        check("rst_echo", bus_if.echo_out, 16'd0);
        check("rst_mic", bus_if.mic_out, 16'd0);
        check("rst_sat", bus_if.sat_cnt, 16'd0);

        // Bypass, half gain
        send(1000, 10, 0, 16'h4000, 500, 510, 0);
        send(-3, 0, 0, 16'h4000, -2, -2, 0);
        drain();

        // D=4 warm-up then small values
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            e = (k <= 4) ? 0 : (((k - 4) * 32767) >>> 15);
            send(k, 0, 4, 16'h7FFF, e, e, 0);
        end
        drain();

        // D=4 with far=1000k: fifth output is 999
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            e = (k <= 4) ? 0 : ((1000 * (k - 4) * 32767) >>> 15);
            send(1000 * k, 0, 4, 16'h7FFF, e, e, 0);
        end
        drain();

        // Wrap with D=63; sample 129 echoes far=66 -> 65
        do_reset();
        for (int i = 0; i < 130; i++) begin
            e = (i < 63) ? 0 : (((i - 63) * 32767) >>> 15);
            if (i == 129) e = 65;
            send(i, 0, 63, 16'h7FFF, e, e, 0);
        end
        drain();

        // Saturation
        do_reset();
        send(-32768, 0, 0, 16'h8000, 32767, 32767, 0);
        send(-32768, 100, 0, 16'h8000, 32767, 32767, 1);
        send(-32768, -32768, 0, 16'h7FFF, -32767, -32768, 1);
        drain();

        // Continuous in_valid: one acceptance every 4 cycles
        do_reset();
        @(negedge clk);
        bus_if.far_in    = '0;
        bus_if.near_in   = 16'd5;
        bus_if.delay_sel = '0;
        bus_if.gain      = '0;
        bus_if.in_valid  = 1'b1;
        rdy = 0;
        for (int c = 0; c < 16; c++) begin
            if (bus_if.in_ready === 1'b1) begin
                rdy++;
                @(posedge clk);
                sb.push_back('{16'd0, 16'd5, sat_exp});
            end else begin
                @(posedge clk);
            end
            @(negedge clk);
        end
        bus_if.in_valid = 1'b0;
        check("ready_cycles_of_16", 16'(rdy), 16'd4);
        drain();

        // Reset during MAC aborts the sample
        do_reset();
        send(20000, 0, 0, 16'h7FFF, 19999, 19999, 0);
        drain();
        @(negedge clk);
        bus_if.far_in    = 16'd30000;
        bus_if.near_in   = 16'd0;
        bus_if.delay_sel = '0;
        bus_if.gain      = 16'h7FFF;
        bus_if.in_valid  = 1'b1;
        @(posedge clk);
        #1 bus_if.in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        sat_exp = '0;
        @(negedge clk);
        check("midrst_out_valid", 16'(bus_if.out_valid), 16'd0);
        check("midrst_echo", bus_if.echo_out, 16'd0);
        check("midrst_mic", bus_if.mic_out, 16'd0);
        check("midrst_sat", bus_if.sat_cnt, 16'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        send(500, 7, 1, 16'h7FFF, 0, 7, 0);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/echo_path_model.md
Name: echo_path_model

Overview:
- Sits directly downstream of the test random-sample source in the echo-cancellation bench.
- Models the acoustic echo path. Each accepted far-end sample x[n] is written into a circular delay line.
- Forms the echo term e[n] = gain * x[n-D] and the microphone sample m[n] = near[n] + e[n], both saturated to 16 bits.
- The adaptive canceller then consumes m[n] as its desired signal and x[n] as its reference.

Parameters:
- DATA_W, 16, sample width for far-end, near-end and outputs (signed two's complement).
- MAX_DELAY, 64, delay-line depth in samples; must be a power of two.
- ADDR_W, 6, log2(MAX_DELAY); width of the pointers and of delay_sel.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  far-end and near-end samples presented.
- in_ready  out  1  block can accept; high exactly when FSM is in IDLE.
- far_in  in  DATA_W  far-end sample x[n], signed.
- near_in  in  DATA_W  near-end talker/noise sample, signed.
- delay_sel  in  ADDR_W  echo delay D in samples, 0..MAX_DELAY-1.
- gain  in  16  echo gain, signed Q1.15.
- out_valid  out  1  one-cycle pulse when echo_out/mic_out update.
- echo_out  out  DATA_W  saturated e[n].
- mic_out  out  DATA_W  saturated m[n].
- sat_cnt  out  16  count of saturation events on mic_out; sticks at 0xFFFF.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM to IDLE; wr_ptr=0; fill_cnt=0.
  - echo_out=0, mic_out=0, out_valid=0, sat_cnt=0.
  - in_ready is 1 once reset is released.
  - Delay-line RAM is not cleared; fill_cnt masks stale entries.
- FSM has four states: IDLE -> READ -> MAC -> OUT -> IDLE. The FSM advances one state per cycle. Throughput is one sample per 4 cycles.
- IDLE:
  - On in_valid && in_ready, latch far_in, near_in, delay_sel and gain.
  - Write far_in to buf[wr_ptr].
  - Compute rd_addr = (wr_ptr - D) mod MAX_DELAY using the pre-increment pointer.
  - Set wr_ptr += 1 (wraps MAX_DELAY-1 -> 0).
  - fill_cnt += 1, saturating at MAX_DELAY-1.
  - Go to READ. in_valid while not in IDLE is ignored (no acceptance).
- READ: registered RAM read of buf[rd_addr].
  - D=0: the bypass uses the latched far_in instead.
  - D > fill_cnt (value before this sample's increment): x[n-D] does not yet exist, and the operand is forced to 0.
- MAC:
  - product = operand * gain, 32-bit signed.
  - e = product >>> 15 (arithmetic shift, truncation toward -inf).
  - Saturate e to [-32768, 32767]. The only overflow case is -32768 * -32768, which gives 32767.
- OUT:
  - sum = near + e, computed at 17 bits and saturated to 16 bits.
  - Register echo_out and mic_out; out_valid=1 for this cycle only.
  - If the mic sum saturated, sat_cnt += 1 unless it is already 0xFFFF.
  - Go to IDLE. Outputs hold their values until the next OUT.
- Latency: acceptance edge -> out_valid high 3 cycles later.
- delay_sel and gain changes take effect only at the next acceptance; they never affect an in-flight sample.
- Reset mid-operation aborts the in-flight sample: no out_valid is produced and the pointer restarts at 0.
- Wrap: after MAX_DELAY writes, the oldest entry is overwritten. D=MAX_DELAY-1 then reads the entry written MAX_DELAY-1 samples earlier.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release -> in_ready=1, out_valid=0, echo_out=mic_out=0, sat_cnt=0.
- Bypass, D=0, gain=0x4000 (0.5):
  - far=1000, near=10 -> 3 cycles later out_valid=1, echo_out=500, mic_out=510.
  - far=-3 -> echo_out=-2 (floor).
- Delay D=4, gain=0x7FFF:
  - Feed far=1,2,3,...,10 with near=0 -> first four outputs echo_out=0 (warm-up).
  - Fifth output uses x=1: 1*32767>>>15 = 0.
  - Repeat with far=1000*k -> fifth output echo_out=999.
- Wrap, D=63: feed 130 samples with far=index -> sample 129 yields echo from far=66 with gain 0x7FFF: 66*32767>>>15 = 65.
- Saturation:
  - far=-32768, gain=0x8000, D=0, near=0 -> echo_out=32767, sat_cnt unchanged.
  - near=100 -> mic_out=32767, sat_cnt increments by 1.
  - far=-32768, gain=0x7FFF, near=-32768 -> mic_out=-32768, sat_cnt increments again.
- Handshake and mid-reset:
  - Hold in_valid=1 continuously -> in_ready is high 1 of every 4 cycles, exactly one acceptance per 4 cycles.
  - Assert rst_n=0 during MAC -> no out_valid pulse, all outputs 0, next sample with D=1 yields echo_out=0.
